// File: rtl/ysyx_22040237_pkg.sv
// Shared definitions for the ysyx_22040237 fetch front end.
//   - YSYX_22040237_RESET_PC : default first fetch address after reset
//   - if_state_e             : fetch FSM state encoding (IDLE / REQ / WAIT)
//   - if_entry_t             : instruction buffer entry {inst, pc, fault}
//   - pc_inc()               : next sequential fetch address (wraps mod 2^32)
package ysyx_22040237_pkg;

    localparam logic [31:0] YSYX_22040237_RESET_PC = 32'h8000_0000;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } if_entry_t;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/ysyx_22040237_if_stage_if.sv
// Bus bundle of the fetch stage.
//   memory request : req_valid, req_ready, req_addr
//   memory response: rsp_valid, rsp_data, rsp_err
//   decode side    : inst_valid, inst_ready, inst, inst_pc, inst_fault
// master = fetch stage view, slave = memory/decode environment view.
interface ysyx_22040237_if_stage_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    modport master (
        output req_valid, req_addr, inst_valid, inst, inst_pc, inst_fault,
        input  req_ready, rsp_valid, rsp_data, rsp_err, inst_ready
    );

    modport slave (
        input  req_valid, req_addr, inst_valid, inst, inst_pc, inst_fault,
        output req_ready, rsp_valid, rsp_data, rsp_err, inst_ready
    );

endinterface

// File: rtl/ysyx_22040237_if_fifo.sv
// Instruction buffer between fetch and decode.
//   clk, rst (async, active-low), flush (drops every entry, wins over push/pop)
//   push/push_entry : write one entry (accepted when not full, or full with a pop)
//   pop             : remove head entry (ignored when empty)
//   out_valid/out_entry : head entry; entry reads as zero while empty
//   count           : current occupancy
// DEPTH must be a power of two, at least 2, so the pointers wrap naturally.
module ysyx_22040237_if_fifo
    import ysyx_22040237_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  if_entry_t                push_entry,
    input  logic                     pop,
    output logic                     out_valid,
    output if_entry_t                out_entry,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    if_entry_t       mem_reg [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;
    logic            pop_ok;
    logic            push_ok;

    assign pop_ok  = pop && (count_reg != '0);
    // A full buffer still takes a push when the head leaves in the same cycle.
    assign push_ok = push && ((count_reg != FULL_COUNT) || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_reg[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push_ok && !pop_ok) begin
                count_reg <= count_reg + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

    assign out_valid = (count_reg != '0);
    // Stale storage is never exposed: outputs read zero while empty.
    assign out_entry = out_valid ? mem_reg[rd_ptr_reg] : '0;
    assign count     = count_reg;

endmodule

// File: rtl/ysyx_22040237_if_stage.sv
// Instruction fetch stage: issues one fetch at a time, buffers returned words
// and hands them to decode; execute-stage redirects flush the buffer.
//   clk, rst (async, active-low)
//   bus (master)   : memory request/response and decode handshake
//   jump_flag/addr : redirect from execute
//   misalign_fault : sticky flag for a misaligned redirect target
// Optional: define YSYX_22040237_IF_MISALIGN_CHK_EN to trap misaligned redirect
// targets; otherwise the low two target bits are forced to zero.
module ysyx_22040237_if_stage
    import ysyx_22040237_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = YSYX_22040237_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22040237_if_stage_if.master      bus,
    input  logic                          jump_flag,
    input  logic [31:0]                   jump_addr,
    output logic                          misalign_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    if_state_e     state_reg, state_next;
    logic [31:0]   fetch_pc_reg, fetch_pc_next;
    logic [31:0]   req_pc_reg;
    logic          drop_reg, drop_next;
    logic          misalign_q;
    logic [31:0]   jump_target;

    logic          handshake;
    logic          push;
    logic          pop;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_after;
    if_entry_t     push_entry;
    if_entry_t     head_entry;
    logic          head_valid;

`ifdef YSYX_22040237_IF_MISALIGN_CHK_EN
    logic misalign_reg;

    assign jump_target = jump_addr;

    // Every redirect re-evaluates the flag: a misaligned target sets it,
    // an aligned one clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_reg <= 1'b0;
        end else if (jump_flag) begin
            misalign_reg <= (jump_addr[1:0] != 2'b00);
        end
    end

    assign misalign_q = misalign_reg;
`else
    logic unused_jump_low;

    assign jump_target     = {jump_addr[31:2], 2'b00};
    assign unused_jump_low = ^jump_addr[1:0];
    assign misalign_q      = 1'b0;
`endif

    assign misalign_fault = misalign_q;

    assign handshake = (state_reg == IF_REQ) && bus.req_ready;
    // A redirect beats the push: the returning word belongs to the old path.
    assign push = (state_reg == IF_WAIT) && bus.rsp_valid && !drop_reg && !jump_flag;
    assign pop  = head_valid && bus.inst_ready;
    assign count_after = fifo_count + CW'(push) - CW'(pop);

    assign push_entry.inst  = bus.rsp_data;
    assign push_entry.pc    = req_pc_reg;
    assign push_entry.fault = bus.rsp_err;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        drop_next     = drop_reg;

        unique case (state_reg)
            IF_IDLE: begin
                // Nothing outstanding here, so occupancy alone decides.
                if ((fifo_count < DEPTH_C) && !misalign_q) state_next = IF_REQ;
            end
            IF_REQ: begin
                if (handshake) begin
                    state_next    = IF_WAIT;
                    fetch_pc_next = pc_inc(fetch_pc_reg);
                end
            end
            IF_WAIT: begin
                if (bus.rsp_valid) begin
                    drop_next  = 1'b0;
                    state_next = ((count_after < DEPTH_C) && !misalign_q) ? IF_REQ : IF_IDLE;
                end
            end
            default: state_next = IF_IDLE;
        endcase

        if (jump_flag) begin
            fetch_pc_next = jump_target;
            // A request still in flight (or launched this very cycle) will
            // answer with a stale word; wait for it and throw it away.
            if (((state_reg == IF_WAIT) && !bus.rsp_valid) || handshake) begin
                state_next = IF_WAIT;
                drop_next  = 1'b1;
            end else begin
                state_next = IF_IDLE;
                drop_next  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IF_IDLE;
            fetch_pc_reg <= RESET_PC;
            req_pc_reg   <= RESET_PC;
            drop_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            drop_reg     <= drop_next;
            if (handshake) req_pc_reg <= fetch_pc_reg;
        end
    end

    ysyx_22040237_if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (jump_flag),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .out_valid  (head_valid),
        .out_entry  (head_entry),
        .count      (fifo_count)
    );

    assign bus.req_valid  = (state_reg == IF_REQ);
    assign bus.req_addr   = fetch_pc_reg;
    assign bus.inst_valid = head_valid;
    assign bus.inst       = head_entry.inst;
    assign bus.inst_pc    = head_entry.pc;
    assign bus.inst_fault = head_entry.fault;

endmodule

// File: doc/ysyx_22040237_if_stage.md
YSYX_22040237_IF_STAGE -- requirements
Module: ysyx_22040237_if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, SHALL set the instruction buffer entry count (power of two, at least 2).
REQ-003 Port clk, input, 1 bit: single clock; all state SHALL be rising-edge triggered.
REQ-004 Port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 Memory request ports: req_valid (out, 1), req_ready (in, 1), req_addr (out, 32): fetch request.
REQ-006 Memory response ports: rsp_valid (in, 1), rsp_data (in, 32), rsp_err (in, 1): instruction word return.
REQ-007 Redirect ports: jump_flag (in, 1) and jump_addr (in, 32): branch or jump redirect from the execute stage.
REQ-008 Decode-side ports: inst_valid (out, 1), inst_ready (in, 1), inst (out, 32), inst_pc (out, 32), inst_fault (out, 1).
REQ-009 Port misalign_fault, output, 1 bit: sticky flag for a misaligned redirect target.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, REQ, WAIT. At most one request SHALL be outstanding.
REQ-011 IDLE SHALL move to REQ when (FIFO occupancy + outstanding) < FIFO_DEPTH and misalign_fault=0.
REQ-012 In REQ, req_valid SHALL be 1 and req_addr SHALL equal fetch_pc.
- On req_valid && req_ready, the FSM SHALL go to WAIT and fetch_pc SHALL advance by 4.
- Without req_ready, req_valid SHALL stay high. req_addr SHALL change only on a redirect.
REQ-013 In WAIT, a response (rsp_valid=1) SHALL push {rsp_data, request pc, rsp_err} into the FIFO, then:
- go to REQ if space remains;
- otherwise go to IDLE.
REQ-014 The FIFO SHALL be registered: a response accepted in cycle N SHALL be visible on inst_valid/inst/inst_pc in cycle N+1.
REQ-015 The decode side SHALL pop on inst_valid && inst_ready. Push and pop in the same cycle SHALL be legal at any occupancy, and occupancy SHALL then be unchanged.
REQ-016 rsp_valid outside WAIT SHALL be ignored.
REQ-017 jump_flag=1 for one cycle SHALL, at the next edge:
- set fetch_pc to jump_addr;
- flush all FIFO entries, so inst_valid=0 the following cycle;
- when in WAIT, or when a handshake coincides with the redirect, set a drop flag.
REQ-018 With the drop flag set, the next response SHALL be discarded and the flag cleared. The FSM SHALL then fetch from the redirect target.
REQ-019 A redirect SHALL take priority over a same-cycle pop, push, or fetch_pc increment.
REQ-020 fetch_pc SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-021 While rst=0, the block SHALL hold: FSM=IDLE, fetch_pc=RESET_PC, FIFO empty, drop flag=0, req_valid=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, misalign_fault=0.
REQ-022 Reset asserted mid-transaction SHALL abandon the outstanding request. The first post-reset response SHALL be ignored because the FSM is not in WAIT.
REQ-023 After rst rises, req_valid SHALL be 1 on the second rising edge.

Configuration
REQ-024 With YSYX_22040237_IF_MISALIGN_CHK_EN defined, a redirect with jump_addr[1:0]!=0 SHALL:
- flush the FIFO;
- set misalign_fault;
- stop new requests until the next aligned redirect clears it.
REQ-025 Without YSYX_22040237_IF_MISALIGN_CHK_EN, jump_addr[1:0] SHALL be forced to 0 and misalign_fault SHALL be tied to 0.

Structure
REQ-026 The FSM state encoding, RESET_PC default, and FIFO entry struct {inst, pc, fault} SHALL live in the shared ysyx_22040237 package.
REQ-027 The buffer SHALL be a sub-module ysyx_22040237_if_fifo with a flush input. The parent SHALL hold the FSM, fetch_pc, and drop logic.

Verification
REQ-028 Reset release, req_ready=1, 1-cycle rsp_data=32'h0010_0093 -> req_addr=32'h8000_0000; inst=32'h0010_0093 and inst_pc=32'h8000_0000 one cycle after rsp_valid.
REQ-029 inst_ready=0 with FIFO_DEPTH=2 -> exactly 2 requests (0x8000_0000, 0x8000_0004), then req_valid=0. One pop -> next req_addr=0x8000_0008.
REQ-030 In WAIT for 0x8000_0004, jump_flag with jump_addr=0x8000_0100 -> FIFO flushed; stale response dropped; next req_addr=0x8000_0100.
REQ-031 rsp_err=1 on a response -> entry delivered with inst_fault=1 and the correct inst_pc; fetching continues at pc+4.
REQ-032 Macro defined, jump_addr=0x8000_0102 -> misalign_fault=1 and no req_valid. Redirect to 0x8000_0200 -> fault cleared and fetch resumes. Macro undefined -> req_addr=0x8000_0100.
REQ-033 rst driven low in WAIT, then released -> all outputs at reset values; first request at RESET_PC; a late response in IDLE is ignored.
